hit_resolver: RTL and testbench
===============================

// Module: hit_resolver
// PURPOSE
//  Upstream arbiter for both gameplay controllers. Reads each player's registered x-position and 4-bit state.
//  Per frame: decides whether an active attack connects and whether it is a hit or a block.
//  Emits one-cycle stunmode pulses to both controllers, tracks health and the round clock, and runs the round FSM.
//  Sits between GameplayControllerP1/P2 outputs and their stunmode inputs; its health/timer/winner outputs feed the HUD renderer.
// PARAMETERS
//  PLAYER_WIDTH   64    sprite width (px); P1 hurtbox right edge = p1_pos_x+64
//  I_REACH        24    neutral-attack reach (px) beyond the attacker's front edge
//  D_REACH        40    directional-attack reach (px)
//  I_DAMAGE       1     health lost on neutral hit
//  D_DAMAGE       2     health lost on directional hit
//  HEALTH_INIT    5     starting health per player (3-bit)
//  ROUND_SECS     90    round length in seconds
//  FRAMES_PER_SEC 60    logic_clk ticks per second
//  KO_HOLD        120   frames spent in S_KO before S_DONE
// PORTS
//  logic_clk      in   1   frame clock (60 Hz or key-step)
//  reset          in   1   asynchronous, active-high
//  p1_pos_x       in   10  P1 left edge
//  p1_state       in   4   P1 controller state
//  p2_pos_x       in   10  P2 left edge
//  p2_state       in   4   P2 controller state
//  stunmode1      out  2   to P1: 00 none, 01 hitstun, 10 blockstun
//  stunmode2      out  2   to P2: same encoding
//  p1_health      out  3   remaining P1 health
//  p2_health      out  3   remaining P2 health
//  round_secs     out  7   seconds remaining
//  freeze         out  1   1 in S_KO/S_DONE; top level masks player inputs
//  game_over      out  1   1 in S_DONE
//  winner         out  2   00 none, 01 P1, 10 P2, 11 draw
// BEHAVIOUR
//  Reset values: stunmode1/2=00, health=HEALTH_INIT, round_secs=ROUND_SECS, sub-counter=0, fsm=S_FIGHT, winner=00, freeze=0, game_over=0, hit latches clear.
//  State codes: IDLE0 FWD1 BWD2 IA_start3 IA_active4 IA_rec5 DA_start6 DA_active7 DA_rec8 HITSTUN9 BLOCKSTUN10.
//  gap = p2_pos_x - (p1_pos_x+PLAYER_WIDTH), computed in 11 bits; clamp to 0 if negative.
//  P1 connects when all hold:
//    - p1_state is 4 with gap<=I_REACH, or p1_state is 7 with gap<=D_REACH
//    - hit_done1==0
//    - fsm==S_FIGHT
//  P2 connect is symmetric.
//  hit_doneN sets on connect. It clears when attacker N's state is neither 4 nor 7, so each active window lands at most once.
//  Block: defender state BWD(2) or BLOCKSTUN(10) -> 10, no damage. Otherwise -> 01, damage by attack type.
//  Latency: connect evaluated in cycle N. The defender's stunmode is 01/10 in cycle N+1 only, then 00.
//    The health decrement is also visible in N+1.
//  Health subtracts with saturation at 0; it never wraps.
//  Trade: both connect in the same cycle -> both pulses and both decrements in N+1.
//  Clock: sub-counter 0..FRAMES_PER_SEC-1. On wrap, round_secs decrements (S_FIGHT only). It stops at 0 with no wrap.
//  FSM:
//    S_FIGHT -> S_KO when any health==0 or round_secs==0 (evaluated on registered values).
//      winner: the sole survivor. Both 0 -> 11.
//      Timeout: the higher health wins; equal health -> 11.
//      winner latches on entry to S_KO.
//    S_KO: freeze=1, stunmode forced 00, no further damage. Counts KO_HOLD frames -> S_DONE.
//    S_DONE: freeze=1, game_over=1. Terminal until reset.
//  Reset mid-pulse or mid-KO: all outputs immediately return to reset values (async).
// STRUCTURE
//  Shared package game_pkg: state codes 0..10, stunmode codes, winner codes, PLAYER_WIDTH. Also used by both controllers.
//  One sub-module, reach_check: gap, attack type and reach compare; instantiated once per attacker direction.
//  Everything else, including the FSM, timers and health registers, lives in hit_resolver.
// TESTING
//  1. p1_x=100, p2_x=180 (gap16), p1_state 3->4 for 2 frames, p2 IDLE -> stunmode2=01 for exactly 1 cycle; p2_health 5->4; no second pulse.
//  2. Same geometry, p1 DA_active(7) 3 frames, p2_state=2 -> stunmode2=10 once; p2_health stays 5.
//  3. gap=41, p1_state=7 -> no pulse; gap=40 -> pulse 01, p2_health -=2.
//  4. Both players in state 4 with gap 10 in the same cycle -> stunmode1=stunmode2=01 same cycle; both health -1.
//  5. p2_health driven to 0 -> fsm S_KO, winner=01, freeze=1; further attacks give no pulses; 120 frames later game_over=1.
//  6. No hits for 90*60 frames, health 5/5 -> round_secs reaches 0, winner=11; assert reset mid-S_KO -> all reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared codes for the gameplay controllers and the hit resolver:
// controller state codes, stunmode/winner codes, sprite geometry.
package game_pkg;

    localparam int PLAYER_WIDTH = 64;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_FWD        = 4'd1;
    localparam logic [3:0] ST_BWD        = 4'd2;
    localparam logic [3:0] ST_IA_START   = 4'd3;
    localparam logic [3:0] ST_IA_ACTIVE  = 4'd4;
    localparam logic [3:0] ST_IA_REC     = 4'd5;
    localparam logic [3:0] ST_DA_START   = 4'd6;
    localparam logic [3:0] ST_DA_ACTIVE  = 4'd7;
    localparam logic [3:0] ST_DA_REC     = 4'd8;
    localparam logic [3:0] ST_HITSTUN    = 4'd9;
    localparam logic [3:0] ST_BLOCKSTUN  = 4'd10;

    localparam logic [1:0] STUN_NONE  = 2'b00;
    localparam logic [1:0] STUN_HIT   = 2'b01;
    localparam logic [1:0] STUN_BLOCK = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        S_FIGHT = 2'd0,
        S_KO    = 2'd1,
        S_DONE  = 2'd2
    } round_state_t;

    // Health never wraps below zero.
    function automatic logic [2:0] sat_sub(input logic [2:0] health, input logic [2:0] dmg);
        return (health > dmg) ? (health - dmg) : 3'd0;
    endfunction

endpackage

// File: rtl/reach_check.sv
// Gap between the two hurtboxes and whether the attacker's active frame
// reaches across it; the gap is symmetric, so one instance serves each attacker.
module reach_check
    import game_pkg::*;
#(
    parameter int I_REACH = 24,
    parameter int D_REACH = 40
) (
    input  logic [9:0] left_x,
    input  logic [9:0] right_x,
    input  logic [3:0] attacker_state,
    output logic       in_reach,
    output logic       directional
);

    logic [11:0] diff;
    logic [10:0] gap;

    // Extra headroom bit so an overlap is always seen as negative, then clamped.
    assign diff = {2'b00, right_x} - ({2'b00, left_x} + 12'(PLAYER_WIDTH));
    assign gap  = diff[11] ? 11'd0 : diff[10:0];

    assign directional = (attacker_state == ST_DA_ACTIVE);
    assign in_reach    = ((attacker_state == ST_IA_ACTIVE) && (gap <= 11'(I_REACH)))
                      || ((attacker_state == ST_DA_ACTIVE) && (gap <= 11'(D_REACH)));

endmodule

// File: rtl/hit_resolver.sv
// Resolves attack connects between both players, emits one-cycle stun pulses,
// tracks health and the round clock, and runs the FIGHT/KO/DONE round FSM.
module hit_resolver
    import game_pkg::*;
#(
    parameter int I_REACH        = 24,
    parameter int D_REACH        = 40,
    parameter int I_DAMAGE       = 1,
    parameter int D_DAMAGE       = 2,
    parameter int HEALTH_INIT    = 5,
    parameter int ROUND_SECS     = 90,
    parameter int FRAMES_PER_SEC = 60,
    parameter int KO_HOLD        = 120
) (
    input  logic       logic_clk,
    input  logic       reset,
    input  logic [9:0] p1_pos_x,
    input  logic [3:0] p1_state,
    input  logic [9:0] p2_pos_x,
    input  logic [3:0] p2_state,
    output logic [1:0] stunmode1,
    output logic [1:0] stunmode2,
    output logic [2:0] p1_health,
    output logic [2:0] p2_health,
    output logic [6:0] round_secs,
    output logic       freeze,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int SUB_W = $clog2(FRAMES_PER_SEC);

    round_state_t     fsm, fsm_next;
    logic [1:0]       winner_next;
    logic [SUB_W-1:0] sub_cnt;
    logic [6:0]       ko_cnt;
    logic             hit_done1, hit_done2;
    logic             reach1, dir1, reach2, dir2;
    logic             connect1, connect2, block1, block2, attacking1, attacking2;
    logic [2:0]       dmg1, dmg2;

    reach_check #(.I_REACH(I_REACH), .D_REACH(D_REACH)) u_reach_p1 (
        .left_x(p1_pos_x), .right_x(p2_pos_x), .attacker_state(p1_state),
        .in_reach(reach1), .directional(dir1)
    );

    reach_check #(.I_REACH(I_REACH), .D_REACH(D_REACH)) u_reach_p2 (
        .left_x(p1_pos_x), .right_x(p2_pos_x), .attacker_state(p2_state),
        .in_reach(reach2), .directional(dir2)
    );

    assign connect1   = reach1 && !hit_done1 && (fsm == S_FIGHT);
    assign connect2   = reach2 && !hit_done2 && (fsm == S_FIGHT);
    assign block1     = (p1_state == ST_BWD) || (p1_state == ST_BLOCKSTUN);
    assign block2     = (p2_state == ST_BWD) || (p2_state == ST_BLOCKSTUN);
    assign attacking1 = (p1_state == ST_IA_ACTIVE) || (p1_state == ST_DA_ACTIVE);
    assign attacking2 = (p2_state == ST_IA_ACTIVE) || (p2_state == ST_DA_ACTIVE);
    assign dmg1       = dir1 ? 3'(D_DAMAGE) : 3'(I_DAMAGE);
    assign dmg2       = dir2 ? 3'(D_DAMAGE) : 3'(I_DAMAGE);

    assign freeze    = (fsm != S_FIGHT);
    assign game_over = (fsm == S_DONE);

    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset) begin
            fsm <= S_FIGHT;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Decisions use the registered health/clock, so a killing blow is shown for a cycle first.
    always_comb begin
        fsm_next    = fsm;
        winner_next = winner;
        case (fsm)
            S_FIGHT: begin
                if ((p1_health == 3'd0) || (p2_health == 3'd0) || (round_secs == 7'd0)) begin
                    fsm_next = S_KO;
                    if ((p1_health == 3'd0) && (p2_health == 3'd0)) winner_next = WIN_DRAW;
                    else if (p1_health == 3'd0)                     winner_next = WIN_P2;
                    else if (p2_health == 3'd0)                     winner_next = WIN_P1;
                    else if (p1_health > p2_health)                 winner_next = WIN_P1;
                    else if (p2_health > p1_health)                 winner_next = WIN_P2;
                    else                                            winner_next = WIN_DRAW;
                end
            end
            S_KO: begin
                if (ko_cnt == 7'(KO_HOLD - 1)) fsm_next = S_DONE;
            end
            default: fsm_next = S_DONE;
        endcase
    end

    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset) begin
            stunmode1  <= STUN_NONE;
            stunmode2  <= STUN_NONE;
            p1_health  <= 3'(HEALTH_INIT);
            p2_health  <= 3'(HEALTH_INIT);
            round_secs <= 7'(ROUND_SECS);
            sub_cnt    <= '0;
            ko_cnt     <= '0;
            hit_done1  <= 1'b0;
            hit_done2  <= 1'b0;
            winner     <= WIN_NONE;
        end else begin
            winner <= winner_next;

            // A latch holds until the attacker leaves its active frames.
            hit_done1 <= connect1 || (hit_done1 && attacking1);
            hit_done2 <= connect2 || (hit_done2 && attacking2);

            stunmode2 <= connect1 ? (block2 ? STUN_BLOCK : STUN_HIT) : STUN_NONE;
            stunmode1 <= connect2 ? (block1 ? STUN_BLOCK : STUN_HIT) : STUN_NONE;
            if (connect1 && !block2) p2_health <= sat_sub(p2_health, dmg1);
            if (connect2 && !block1) p1_health <= sat_sub(p1_health, dmg2);

            if (fsm == S_FIGHT) begin
                if (sub_cnt == SUB_W'(FRAMES_PER_SEC - 1)) begin
                    sub_cnt <= '0;
                    if (round_secs != 7'd0) round_secs <= round_secs - 7'd1;
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end

            ko_cnt <= (fsm == S_KO) ? ko_cnt + 7'd1 : 7'd0;
        end
    end

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: expected outputs are queued as each frame is
// driven and compared one cycle later, after the clock edge.
module tb_hit_resolver;

    logic       logic_clk = 1'b0;
    logic       reset;
    logic [9:0] p1_pos_x, p2_pos_x;
    logic [3:0] p1_state, p2_state;
    logic [1:0] stunmode1, stunmode2, winner;
    logic [2:0] p1_health, p2_health;
    logic [6:0] round_secs;
    logic       freeze, game_over;

    int total = 0;
    int bad   = 0;
    logic [13:0] exp_q[$];

    logic [2:0] e_h1, e_h2;
    logic [1:0] e_win;
    logic       e_fz, e_go;
    logic [6:0] e_rs;

    hit_resolver dut (
        .logic_clk(logic_clk), .reset(reset),
        .p1_pos_x(p1_pos_x), .p1_state(p1_state),
        .p2_pos_x(p2_pos_x), .p2_state(p2_state),
        .stunmode1(stunmode1), .stunmode2(stunmode2),
        .p1_health(p1_health), .p2_health(p2_health),
        .round_secs(round_secs), .freeze(freeze),
        .game_over(game_over), .winner(winner)
    );

    always #5 logic_clk = ~logic_clk;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed as {stun1, stun2, h1, h2, freeze, game_over, winner}.
    function automatic logic [13:0] observed();
        return {stunmode1, stunmode2, p1_health, p2_health, freeze, game_over, winner};
    endfunction

    task automatic step(input string tag, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [1:0] es1, input logic [1:0] es2);
        logic [13:0] e;
        p1_state = s1;
        p2_state = s2;
        exp_q.push_back({es1, es2, e_h1, e_h2, e_fz, e_go, e_win});
        @(posedge logic_clk);
        #1;
        e = exp_q.pop_front();
        cmp(tag, 16'(observed()), 16'(e));
        cmp({tag, "_secs"}, 16'(round_secs), 16'(e_rs));
    endtask

    task automatic check_reset(input string tag);
        cmp(tag, 16'(observed()), 16'({2'b00, 2'b00, 3'd5, 3'd5, 1'b0, 1'b0, 2'b00}));
        cmp({tag, "_secs"}, 16'(round_secs), 16'd90);
    endtask

    task automatic clear_expect();
        e_h1 = 3'd5; e_h2 = 3'd5; e_win = 2'b00; e_fz = 1'b0; e_go = 1'b0; e_rs = 7'd90;
    endtask

    initial begin
        reset = 1'b1;
        p1_pos_x = 10'd100; p2_pos_x = 10'd180;
        p1_state = 4'd0;    p2_state = 4'd0;
        clear_expect();
        #12;
        check_reset("reset_init");
        reset = 1'b0;

        // Neutral hit at gap 16: one hitstun pulse, one point of damage, no repeat.
        step("t1_startup", 4'd3, 4'd0, 2'b00, 2'b00);
        e_h2 = 3'd4;
        step("t1_hit",     4'd4, 4'd0, 2'b00, 2'b01);
        step("t1_nodup",   4'd4, 4'd0, 2'b00, 2'b00);
        step("t1_idle",    4'd0, 4'd0, 2'b00, 2'b00);

        // Directional attack into a backing-off defender is blocked.
        step("t2_startup", 4'd6, 4'd2, 2'b00, 2'b00);
        step("t2_block",   4'd7, 4'd2, 2'b00, 2'b10);
        step("t2_nodup1",  4'd7, 4'd2, 2'b00, 2'b00);
        step("t2_nodup2",  4'd7, 4'd2, 2'b00, 2'b00);
        step("t2_idle",    4'd0, 4'd2, 2'b00, 2'b00);

        // Directional reach boundary: 41 misses, 40 lands for two damage.
        p2_pos_x = 10'd205;
        step("t3_gap41",   4'd7, 4'd0, 2'b00, 2'b00);
        p2_pos_x = 10'd204;
        e_h2 = 3'd2;
        step("t3_gap40",   4'd7, 4'd0, 2'b00, 2'b01);
        step("t3_idle",    4'd0, 4'd0, 2'b00, 2'b00);

        // Trade: both neutral attacks land on the same frame.
        p2_pos_x = 10'd174;
        e_h1 = 3'd4; e_h2 = 3'd1;
        step("t4_trade",   4'd4, 4'd4, 2'b01, 2'b01);
        step("t4_idle",    4'd0, 4'd0, 2'b00, 2'b00);

        // Two damage on one health saturates at zero, then KO for P1.
        e_h2 = 3'd0;
        step("t5_lethal",  4'd7, 4'd0, 2'b00, 2'b01);
        e_win = 2'b01; e_fz = 1'b1;
        step("t5_ko",      4'd0, 4'd0, 2'b00, 2'b00);
        for (int i = 1; i < 120; i++) begin
            step("t5_frozen", 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)), 2'b00, 2'b00);
        end
        e_go = 1'b1;
        step("t5_done",    4'd4, 4'd4, 2'b00, 2'b00);
        step("t5_hold",    4'd7, 4'd7, 2'b00, 2'b00);

        // Fresh round with no contact runs the clock out to a draw.
        reset = 1'b1;
        #2;
        check_reset("reset_done");
        reset = 1'b0;
        clear_expect();
        p1_pos_x = 10'd0; p2_pos_x = 10'd900;
        for (int k = 1; k <= 90 * 60; k++) begin
            e_rs = 7'(90 - k / 60);
            step("t6_clock", 4'd0, 4'd0, 2'b00, 2'b00);
        end
        e_win = 2'b11; e_fz = 1'b1;
        step("t6_timeout", 4'd0, 4'd0, 2'b00, 2'b00);
        step("t6_ko",      4'd4, 4'd4, 2'b00, 2'b00);

        // Asynchronous reset in the middle of KO, between clock edges.
        reset = 1'b1;
        #2;
        check_reset("reset_mid_ko");
        reset = 1'b0;
        clear_expect();
        step("t6_after",   4'd0, 4'd0, 2'b00, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
